crank_sync_sequencer: RTL and testbench

Parametrised successor to the crank position / stroke transition pair. It resynchronises the raw CKP input and detects the missing-tooth gap by period ratio. From that it maintains an absolute 720° tooth position and derives per-cylinder stroke, injection and ignition windows for any tooth count and any cylinder count. It sits between the CKP/CMP sensor pins and the injection/ignition controllers, and exports the last tooth period for RPM/BTDC calculation.

---
 rtl/crank_sync_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_crank_sync_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/crank_sync_sequencer.sv
// Missing-tooth crank decoder: 720-degree tooth position, per-cylinder stroke and injection/ignition windows.
// Latency: tooth_edge/tooth_pos/tooth_period 3 clk after ckp is first sampled high, stroke/allow_* 1 clk later; no backpressure.
module crank_sync_sequencer #(
    parameter int NUM_TEETH     = 36,
    parameter int MISSING_TEETH = 1,
    parameter int CYLINDERS     = 4,
    parameter int PERIOD_WIDTH  = 24,
    parameter int STALL_CYCLES  = 12500000,
    parameter int GAP_SHIFT     = 1,
    parameter int CAM_ENABLE    = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             on,
    input  logic                             ckp,
    input  logic                             cmp,
    output logic                             sync,
    output logic                             tooth_edge,
    output logic [$clog2(2*NUM_TEETH)-1:0]   tooth_pos,
    output logic [PERIOD_WIDTH-1:0]          tooth_period,
    output logic [CYLINDERS*2-1:0]           stroke,
    output logic [CYLINDERS-1:0]             allow_injection,
    output logic [CYLINDERS-1:0]             allow_ignition,
    output logic                             stall
);
    localparam int POS_W      = $clog2(2*NUM_TEETH);
    localparam int LAST_TOOTH = NUM_TEETH - MISSING_TEETH - 1;
    localparam logic [PERIOD_WIDTH-1:0] STALL_LIMIT = PERIOD_WIDTH'(STALL_CYCLES);

    if ((NUM_TEETH % 2) != 0 || MISSING_TEETH < 1 || MISSING_TEETH > NUM_TEETH/4 ||
        ((2*NUM_TEETH) % CYLINDERS) != 0) begin : g_bad_params
        $error("crank_sync_sequencer: illegal NUM_TEETH/MISSING_TEETH/CYLINDERS combination");
    end

    typedef enum logic [1:0] {IDLE, SEEK, SYNCED, LOST} state_t;

    state_t                  state;
    logic [1:0]              ckp_sync_q;
    logic [1:0]              cmp_sync_q;
    logic                    ckp_last;
    logic                    edge_evt;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] prev_period;
    logic [1:0]              edge_cnt;

    logic [PERIOD_WIDTH:0]   gap_thresh;
    logic                    gap;
    logic                    cmp_s;
    logic                    at_last_tooth;
    logic                    cam_ok;
    logic [POS_W-1:0]        boundary;
    logic [POS_W-1:0]        pos_inc;

    // Edge event is registered once more so the FSM sees it 3 clk after the first high sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            ckp_sync_q <= '0;
            cmp_sync_q <= '0;
            ckp_last   <= 1'b0;
            edge_evt   <= 1'b0;
        end else begin
            ckp_sync_q <= {ckp_sync_q[0], ckp};
            cmp_sync_q <= {cmp_sync_q[0], cmp};
            ckp_last   <= ckp_sync_q[1];
            edge_evt   <= ckp_sync_q[1] & ~ckp_last;
        end
    end

    always_comb begin
        cmp_s         = cmp_sync_q[1];
        gap_thresh    = {1'b0, prev_period} + {1'b0, prev_period >> GAP_SHIFT};
        gap           = ({1'b0, cnt} > gap_thresh) && edge_cnt[1];
        at_last_tooth = (tooth_pos == POS_W'(LAST_TOOTH)) ||
                        (tooth_pos == POS_W'(LAST_TOOTH + NUM_TEETH));
        boundary      = (tooth_pos < POS_W'(NUM_TEETH)) ? POS_W'(NUM_TEETH) : '0;
        cam_ok        = (CAM_ENABLE == 0) || (cmp_s == (boundary == '0));
        pos_inc       = (tooth_pos == POS_W'(2*NUM_TEETH - 1)) ? '0 : tooth_pos + POS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || !on) begin
            state        <= IDLE;
            cnt          <= '0;
            prev_period  <= '0;
            tooth_period <= '0;
            edge_cnt     <= '0;
            tooth_pos    <= '0;
            tooth_edge   <= 1'b0;
            sync         <= 1'b0;
            stall        <= 1'b0;
        end else begin
            tooth_edge <= 1'b0;
            if (edge_evt) begin
                cnt          <= PERIOD_WIDTH'(1);
                tooth_period <= cnt;
                prev_period  <= tooth_period;
                stall        <= 1'b0;
            end else begin
                if (~&cnt) cnt <= cnt + PERIOD_WIDTH'(1);
                if (cnt == STALL_LIMIT) stall <= 1'b1;
            end

            if (edge_evt && state != IDLE && !edge_cnt[1])
                edge_cnt <= edge_cnt + 2'd1;

            if (!edge_evt && cnt == STALL_LIMIT) begin
                state     <= IDLE;
                sync      <= 1'b0;
                tooth_pos <= '0;
                edge_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tooth_pos <= '0;
                        edge_cnt  <= '0;
                        sync      <= 1'b0;
                        state     <= SEEK;
                    end
                    SEEK: if (edge_evt) begin
                        tooth_edge <= 1'b1;
                        if (gap) begin
                            tooth_pos <= (CAM_ENABLE == 0 || cmp_s) ? '0 : POS_W'(NUM_TEETH);
                            sync      <= 1'b1;
                            state     <= SYNCED;
                        end
                    end
                    SYNCED: if (edge_evt) begin
                        tooth_edge <= 1'b1;
                        if (gap) begin
                            if (at_last_tooth && cam_ok) begin
                                tooth_pos <= boundary;
                            end else begin
                                sync  <= 1'b0;
                                state <= LOST;
                            end
                        end else if (at_last_tooth) begin
                            // A regular tooth where the gap belongs: the gap was missed.
                            sync  <= 1'b0;
                            state <= LOST;
                        end else begin
                            tooth_pos <= pos_inc;
                        end
                    end
                    default: begin
                        if (edge_evt) tooth_edge <= 1'b1;
                        state <= SEEK;
                    end
                endcase
            end
        end
    end

    logic [CYLINDERS*2-1:0] stroke_nxt;
    logic [CYLINDERS-1:0]   inj_nxt;
    logic [CYLINDERS-1:0]   ign_nxt;

    always_comb begin
        int         p;
        logic [1:0] s;
        stroke_nxt = '0;
        inj_nxt    = '0;
        ign_nxt    = '0;
        p          = 0;
        s          = '0;
        for (int i = 0; i < CYLINDERS; i++) begin
            p = (int'(tooth_pos) + 2*NUM_TEETH - (i*2*NUM_TEETH)/CYLINDERS) % (2*NUM_TEETH);
            s = 2'(p / (NUM_TEETH/2));
            stroke_nxt[2*i +: 2] = s;
            inj_nxt[i]           = (s == 2'd0);
            ign_nxt[i]           = (s == 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !on || !sync) begin
            stroke          <= '0;
            allow_injection <= '0;
            allow_ignition  <= '0;
        end else begin
            stroke          <= stroke_nxt;
            allow_injection <= inj_nxt;
            allow_ignition  <= ign_nxt;
        end
    end
endmodule

// File: tb/tb_crank_sync_sequencer.sv
// Directed bench: 36-1/4-cyl cam-phased decoder plus a 60-2/6-cyl cam-less decoder.
module tb_crank_sync_sequencer;
    localparam int P_A = 20;
    localparam int P_B = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic on_a, ckp_a, cmp_a, on_b, ckp_b, cmp_b;

    logic        sync_a, tooth_edge_a, stall_a;
    logic [6:0]  tooth_pos_a;
    logic [23:0] tooth_period_a;
    logic [7:0]  stroke_a;
    logic [3:0]  inj_a, ign_a;

    logic        sync_b, tooth_edge_b, stall_b;
    logic [6:0]  tooth_pos_b;
    logic [23:0] tooth_period_b;
    logic [11:0] stroke_b;
    logic [5:0]  inj_b, ign_b;

    crank_sync_sequencer #(
        .NUM_TEETH(36), .MISSING_TEETH(1), .CYLINDERS(4), .PERIOD_WIDTH(24),
        .STALL_CYCLES(2000), .GAP_SHIFT(1), .CAM_ENABLE(1)
    ) dut_a (
        .clk(clk), .reset(reset), .on(on_a), .ckp(ckp_a), .cmp(cmp_a),
        .sync(sync_a), .tooth_edge(tooth_edge_a), .tooth_pos(tooth_pos_a),
        .tooth_period(tooth_period_a), .stroke(stroke_a),
        .allow_injection(inj_a), .allow_ignition(ign_a), .stall(stall_a)
    );

    crank_sync_sequencer #(
        .NUM_TEETH(60), .MISSING_TEETH(2), .CYLINDERS(6), .PERIOD_WIDTH(24),
        .STALL_CYCLES(100000), .GAP_SHIFT(1), .CAM_ENABLE(0)
    ) dut_b (
        .clk(clk), .reset(reset), .on(on_b), .ckp(ckp_b), .cmp(cmp_b),
        .sync(sync_b), .tooth_edge(tooth_edge_b), .tooth_pos(tooth_pos_b),
        .tooth_period(tooth_period_b), .stroke(stroke_b),
        .allow_injection(inj_b), .allow_ignition(ign_b), .stall(stall_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Snapshot of one tooth: edge-cycle values and the following cycle.
    logic        t_edge, t_edge2, t_sync, t_sync2, t_stall;
    logic [6:0]  t_pos;
    logic [23:0] t_period;
    logic [11:0] t_stroke;
    logic [5:0]  t_inj, t_ign;

    logic        log_edge [64];
    logic        log_edge2[64];
    logic        log_sync [64];
    logic        log_sync2[64];
    logic [6:0]  log_pos  [64];
    logic [23:0] log_per  [64];
    logic [11:0] log_str  [64];
    logic [5:0]  log_inj  [64];
    logic [5:0]  log_ign  [64];

    // Called at a negedge; drives one ckp rising edge and holds for 'period' clocks.
    task automatic tooth(input bit b, input int period);
        if (b) ckp_b = 1'b1; else ckp_a = 1'b1;
        for (int i = 1; i <= period; i++) begin
            @(negedge clk);
            if (i == 4) begin
                t_edge   = b ? tooth_edge_b   : tooth_edge_a;
                t_sync   = b ? sync_b         : sync_a;
                t_pos    = b ? tooth_pos_b    : tooth_pos_a;
                t_period = b ? tooth_period_b : tooth_period_a;
                t_stall  = b ? stall_b        : stall_a;
            end
            if (i == 5) begin
                t_edge2  = b ? tooth_edge_b : tooth_edge_a;
                t_sync2  = b ? sync_b : sync_a;
                t_stroke = b ? stroke_b : {4'b0, stroke_a};
                t_inj    = b ? inj_b : {2'b0, inj_a};
                t_ign    = b ? ign_b : {2'b0, ign_a};
            end
            if (i == period/2) begin
                if (b) ckp_b = 1'b0; else ckp_a = 1'b0;
            end
        end
    endtask

    task automatic log_tooth(input int t);
        log_edge[t]  = t_edge;
        log_edge2[t] = t_edge2;
        log_sync[t]  = t_sync;
        log_sync2[t] = t_sync2;
        log_pos[t]   = t_pos;
        log_per[t]   = t_period;
        log_str[t]   = t_stroke;
        log_inj[t]   = t_inj;
        log_ign[t]   = t_ign;
    endtask

    // One revolution of present teeth; the last interval spans the gap. cam = cmp level for the whole rev.
    task automatic rev(input bit b, input bit cam, input int extra);
        int nt;
        int p;
        int gapmul;
        nt     = (b ? 58 : 35) + extra;
        p      = b ? P_B : P_A;
        gapmul = b ? 3 : 2;
        if (b) cmp_b = cam; else cmp_a = cam;
        for (int t = 0; t < nt; t++) begin
            tooth(b, (t == nt-1) ? p*gapmul : p);
            log_tooth(t);
        end
    endtask

    initial begin
        reset = 1'b1;
        on_a = 1'b0; ckp_a = 1'b0; cmp_a = 1'b0;
        on_b = 1'b0; ckp_b = 1'b0; cmp_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sync",   32'(sync_a), 0);
        check("rst_edge",   32'(tooth_edge_a), 0);
        check("rst_pos",    32'(tooth_pos_a), 0);
        check("rst_period", 32'(tooth_period_a), 0);
        check("rst_stroke", 32'(stroke_a), 0);
        check("rst_inj",    32'(inj_a), 0);
        check("rst_ign",    32'(ign_a), 0);
        check("rst_stall",  32'(stall_a), 0);

        reset = 1'b0;
        on_a  = 1'b1;
        repeat (2*P_A) @(negedge clk);

        rev(0, 1'b1, 0);
        check("seek_no_sync", 32'(log_sync[34]), 0);

        rev(0, 1'b1, 0);
        check("gap_edge",     32'(log_edge[0]), 1);
        check("gap_sync",     32'(log_sync[0]), 1);
        check("gap_pos0",     32'(log_pos[0]), 0);
        check("gap_period",   32'(log_per[0]), 40);
        check("edge_1cycle",  32'(log_edge2[1]), 0);
        check("pos1",         32'(log_pos[1]), 1);
        check("period_1000",  32'(log_per[1]), 20);
        check("p9_stroke",    32'(log_str[9]), 32'h6C);
        check("p9_inj",       32'(log_inj[9]), 32'b0001);
        check("p9_ign",       32'(log_ign[9]), 32'b1000);
        check("p20_stroke",   32'(log_str[20]), 32'hB1);
        check("p20_inj",      32'(log_inj[20]), 32'b0010);
        check("p20_ign",      32'(log_ign[20]), 32'b0001);
        check("pos34",        32'(log_pos[34]), 34);

        rev(0, 1'b0, 0);
        check("rev2_sync",    32'(log_sync[0]), 1);
        check("rev2_pos36",   32'(log_pos[0]), 36);
        check("rev2_pos37",   32'(log_pos[1]), 37);
        check("p56_stroke",   32'(log_str[20]), 32'h1B);
        check("p56_inj",      32'(log_inj[20]), 32'b1000);
        check("p56_ign",      32'(log_ign[20]), 32'b0100);

        // Extra tooth: 36 uniform teeth, the last lands where the gap should be.
        rev(0, 1'b1, 1);
        check("extra_pre_sync", 32'(log_sync[34]), 1);
        check("extra_lost_sync", 32'(log_sync[35]), 0);
        check("extra_lost_stroke", 32'(log_str[35]), 0);
        check("extra_lost_inj", 32'(log_inj[35]), 0);
        check("extra_lost_ign", 32'(log_ign[35]), 0);
        check("extra_after_sync", 32'(log_sync2[35]), 0);

        rev(0, 1'b1, 0);
        check("resync_sync",  32'(log_sync[0]), 1);
        check("resync_pos",   32'(log_pos[0]), 0);

        // Next boundary is N, so cmp=1 contradicts the cam phase.
        rev(0, 1'b1, 0);
        check("cam_mismatch_lost", 32'(log_sync[0]), 0);
        rev(0, 1'b0, 0);
        check("seek_cmp0_sync", 32'(log_sync[0]), 1);
        check("seek_cmp0_pos",  32'(log_pos[0]), 36);

        repeat (2100) @(negedge clk);
        check("stall_set",     32'(stall_a), 1);
        check("stall_nosync",  32'(sync_a), 0);
        tooth(0, 2*P_A);
        check("stall_cleared", 32'(t_stall), 0);
        tooth(0, P_A);
        check("stall_no_early_gap", 32'(t_sync), 0);
        rev(0, 1'b1, 0);
        rev(0, 1'b1, 0);
        check("stall_resync",  32'(log_sync[0]), 1);
        check("stall_resync_pos", 32'(log_pos[0]), 0);

        check("pre_off_sync",  32'(sync_a), 1);
        on_a = 1'b0;
        @(negedge clk);
        check("off_sync",      32'(sync_a), 0);
        check("off_pos",       32'(tooth_pos_a), 0);
        check("off_period",    32'(tooth_period_a), 0);
        check("off_stroke",    32'(stroke_a), 0);
        check("off_inj",       32'(inj_a), 0);

        on_b = 1'b1;
        repeat (2*P_B) @(negedge clk);
        rev(1, 1'b0, 0);
        check("b_seek_no_sync", 32'(log_sync[57]), 0);
        rev(1, 1'b0, 0);
        check("b_sync",        32'(log_sync[0]), 1);
        check("b_pos0",        32'(log_pos[0]), 0);
        check("b_gap_period",  32'(log_per[0]), 30);
        check("b_p0_stroke",   32'(log_str[0]), 32'h1AC);
        check("b_p0_inj",      32'(log_inj[0]), 32'b100001);
        check("b_p0_ign",      32'(log_ign[0]), 32'b010000);
        check("b_pos57",       32'(log_pos[57]), 57);
        rev(1, 1'b1, 0);
        check("b_pos60",       32'(log_pos[0]), 60);
        check("b_p60_stroke",  32'(log_str[0]), 32'hB06);
        check("b_p60_inj",     32'(log_inj[0]), 32'b001100);
        check("b_p60_ign",     32'(log_ign[0]), 32'b000010);
        rev(1, 1'b1, 0);
        check("b_alt_pos0",    32'(log_pos[0]), 0);
        check("b_alt_sync",    32'(log_sync[0]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
